dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Load/store bridge sitting directly downstream of the RV32 core's data-memory port (address, write data, mask, write enable). Converts each core access into one word-aligned bus transaction with valid/ready handshake and byte strobes, then returns sign/zero-extended load data. Stalls the core until the transaction completes and flags misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT, 255, max cycles spent in REQ or WAIT before an access aborts with error; 0 disables the timeout.

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-high
core_req_i  in  1  current instruction is a load/store
core_wen_i  in  1  1 = store, 0 = load
core_addr_i  in  32  byte address
core_wdata_i  in  32  store data (LSBs significant)
core_mask_i  in  3  funct3 size: 000 B, 001 H, 010 W, 100 BU, 101 HU
core_rdata_o  out  32  extended load data, valid in DONE
core_stall_o  out  1  hold core PC/regfile write
core_err_o  out  1  one-cycle pulse: misaligned, illegal mask or timeout
bus_valid_o  out  1  request valid
bus_ready_i  in  1  request accepted
bus_we_o  out  1  write request
bus_addr_o  out  32  word address, bits [1:0] = 00
bus_wdata_o  out  32  lane-replicated write data
bus_strb_o  out  4  byte strobes (write only; 0000 on reads)
bus_rvalid_i  in  1  read data valid
bus_rdata_i  in  32  read word

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Asynchronous: bus_valid_o drops immediately, even mid-transaction.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: core_req_i=1 with legal, aligned access -> core_stall_o=1 (combinational), latch addr/wdata/mask/wen, go REQ. Misaligned (H with addr[0]=1; W with addr[1:0]!=00) or illegal mask (011,110,111) -> no bus access, core_err_o=1 and core_stall_o=0 same cycle, core_rdata_o=0, stay IDLE.
- REQ: bus_valid_o=1, bus_* driven from latched values, held stable until bus_ready_i=1. On handshake: store -> DONE; load -> WAIT. core_stall_o=1.
- WAIT: core_stall_o=1; on bus_rvalid_i capture formatted data into core_rdata_o register -> DONE. rvalid is sampled only in WAIT (never in REQ or the handshake cycle).
- DONE: core_stall_o=0 for exactly one cycle; core commits; next state IDLE unconditionally (core_req_i in DONE belongs to the finishing instruction and is ignored).
- Timeout: counter clears on entry to REQ and on handshake; increments each cycle in REQ/WAIT; reaching TIMEOUT -> core_err_o pulse, core_rdata_o=0, bus_valid_o dropped, go DONE.
- Strobes/data: B: strb=0001<<addr[1:0], wdata={4{byte}}; H: strb=0011<<(2*addr[1]), wdata={2{half}}; W: 1111, wdata unchanged.
- Loads: lane selected by latched addr[1:0]/addr[1]; 000/001 sign-extend, 100/101 zero-extend, 010 whole word.
- Latency: store with ready in first REQ cycle = 3 cycles (IDLE,REQ,DONE); load with rvalid first WAIT cycle = 4 cycles.
- Stray bus_rvalid_i in IDLE/REQ/DONE ignored (covers responses outstanding across reset).
- core_rdata_o holds its value outside DONE until next capture.

Decomposition:
- Package dmem_pkg: size encodings (MASK_B/H/W/BU/HU), state enum, strobe constants.
- Sub-module dmem_align: combinational strobe/wdata replication and load extraction/extension; dmem_ctrl holds FSM, latches, timeout counter.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ready held 1 -> bus_addr 0x100, strb 1111, wdata 0xDEADBEEF; stall 2 cycles, DONE on 3rd.
- SB addr 0x203, data 0x000000A5 -> bus_addr 0x200, strb 1000, wdata 0xA5A5A5A5.
- LB addr 0x301, bus_rdata 0x1234_80FF, rvalid 2 cycles after handshake -> core_rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x302 -> 0x00001234.
- LW addr 0x102 -> core_err_o pulse same cycle, stall 0, bus_valid_o never asserted; mask 011 likewise.
- TIMEOUT=4, ready held 0 -> err pulse after 4 REQ cycles, bus_valid_o drops, rdata 0, back to IDLE via DONE.
- reset_i asserted during WAIT -> bus_valid_o/stall 0 immediately; late rvalid after release ignored, next LW completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store bridge: access sizes,
// controller states, byte-strobe patterns and the alignment legality check.
package dmem_pkg;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  // Legal size encoding with natural alignment for that size.
  function automatic logic access_ok(input logic [2:0] mask, input logic [1:0] addr_lo);
    logic ok;
    case (mask)
      MASK_B, MASK_BU: ok = 1'b1;
      MASK_H, MASK_HU: ok = ~addr_lo[0];
      MASK_W:          ok = (addr_lo == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: store strobes and data replication, and load lane
// extraction with sign or zero extension.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  mask,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword out of the returned word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Store strobes and replicated write data, plus extended load data.
  always_comb begin
    strb      = STRB_NONE;
    wdata_rep = wdata;
    rdata_ext = 32'h0000_0000;
    case (mask)
      MASK_B, MASK_BU: begin
        strb      = STRB_B << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MASK_H, MASK_HU: begin
        strb      = STRB_H << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      MASK_W: begin
        strb      = STRB_W;
        wdata_rep = wdata;
      end
      default: begin
        strb      = STRB_NONE;
        wdata_rep = wdata;
      end
    endcase
    case (mask)
      MASK_B:  rdata_ext = {{24{byte_s[7]}}, byte_s};
      MASK_BU: rdata_ext = {24'h00_0000, byte_s};
      MASK_H:  rdata_ext = {{16{half_s[15]}}, half_s};
      MASK_HU: rdata_ext = {16'h0000, half_s};
      MASK_W:  rdata_ext = rdata;
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory bridge between the core's load/store port and a valid/ready
// word bus: one bus transaction per access, core stalled until it completes.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        core_req_i,
  input  logic        core_wen_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [2:0]  core_mask_i,
  output logic [31:0] core_rdata_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_strb_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic            TMO_EN   = (TIMEOUT > 0);

  dmem_state_e      state_r, state_next_s;
  logic [31:0]      addr_r, wdata_r, rdata_r;
  logic [2:0]       mask_r;
  logic             wen_r, tmo_err_r;
  logic [CNT_W-1:0] cnt_r;

  logic [3:0]  strb_s;
  logic [31:0] wdata_rep_s, rdata_ext_s;
  logic        ok_s, accept_s, reject_s, handshake_s, capture_s, tmo_hit_s;

  assign ok_s = access_ok(core_mask_i, core_addr_i[1:0]);

  dmem_align u_align (
    .mask      (mask_r),
    .addr_lo   (addr_r[1:0]),
    .wdata     (wdata_r),
    .rdata     (bus_rdata_i),
    .strb      (strb_s),
    .wdata_rep (wdata_rep_s),
    .rdata_ext (rdata_ext_s)
  );

  // Next-state decode; a completing handshake or read beat wins over timeout.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    handshake_s  = 1'b0;
    capture_s    = 1'b0;
    tmo_hit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (core_req_i && !reset_i && ok_s) begin
          accept_s     = 1'b1;
          state_next_s = ST_REQ;
        end else if (core_req_i && !reset_i) begin
          reject_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_ready_i) begin
          handshake_s  = 1'b1;
          state_next_s = wen_r ? ST_DONE : ST_WAIT;
        end else if (TMO_EN && (cnt_r == CNT_LAST)) begin
          tmo_hit_s    = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid_i) begin
          capture_s    = 1'b1;
          state_next_s = ST_DONE;
        end else if (TMO_EN && (cnt_r == CNT_LAST)) begin
          tmo_hit_s    = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Core-facing and bus-facing outputs; bus side is quiet outside REQ.
  always_comb begin
    core_stall_o = accept_s || (state_r == ST_REQ) || (state_r == ST_WAIT);
    core_err_o   = reject_s || ((state_r == ST_DONE) && tmo_err_r);
    core_rdata_o = reject_s ? 32'h0000_0000 : rdata_r;
    bus_valid_o  = (state_r == ST_REQ);
    bus_we_o     = (state_r == ST_REQ) && wen_r;
    if (state_r == ST_REQ) begin
      bus_addr_o  = {addr_r[31:2], 2'b00};
      bus_wdata_o = wdata_rep_s;
    end else begin
      bus_addr_o  = 32'h0000_0000;
      bus_wdata_o = 32'h0000_0000;
    end
    if ((state_r == ST_REQ) && wen_r) begin
      bus_strb_o = strb_s;
    end else begin
      bus_strb_o = STRB_NONE;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Access latches, captured once when the core request is accepted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      mask_r  <= 3'b000;
      wen_r   <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= core_addr_i;
      wdata_r <= core_wdata_i;
      mask_r  <= core_mask_i;
      wen_r   <= core_wen_i;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      mask_r  <= mask_r;
      wen_r   <= wen_r;
    end
  end

  // Timeout counter restarts per phase so REQ and WAIT each get the full budget.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (accept_s || handshake_s) begin
      cnt_r <= '0;
    end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Load result register and the registered timeout error reported in DONE.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdata_r   <= 32'h0000_0000;
      tmo_err_r <= 1'b0;
    end else begin
      tmo_err_r <= tmo_hit_s;
      if (capture_s) begin
        rdata_r <= rdata_ext_s;
      end else if (tmo_hit_s || reject_s) begin
        rdata_r <= 32'h0000_0000;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table of single accesses plus
// hand-written timeout and reset-mid-transaction sequences.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        core_req_i, core_wen_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic [2:0]  core_mask_i;
  logic [31:0] core_rdata_o;
  logic        core_stall_o, core_err_o;
  logic        bus_valid_o, bus_ready_i, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_strb_o;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_rdata;

  dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .core_req_i   (core_req_i),
    .core_wen_i   (core_wen_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_mask_i  (core_mask_i),
    .core_rdata_o (core_rdata_o),
    .core_stall_o (core_stall_o),
    .core_err_o   (core_err_o),
    .bus_valid_o  (bus_valid_o),
    .bus_ready_i  (bus_ready_i),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_strb_o   (bus_strb_o),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mask;
    int          rdy_dly;
    int          rv_dly;
    logic [31:0] bus_rdata;
    logic        exp_err;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk_i);
    core_req_i   = 1'b1;
    core_wen_i   = v.wen;
    core_addr_i  = v.addr;
    core_wdata_i = v.wdata;
    core_mask_i  = v.mask;
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b0;
    #1;
    if (v.exp_err) begin
      chk({p, "_err"},   {31'd0, core_err_o},   32'd1);
      chk({p, "_stall"}, {31'd0, core_stall_o}, 32'd0);
      chk({p, "_rdata"}, core_rdata_o,          32'h0);
      last_rdata = 32'h0;
      @(negedge clk_i);
      chk({p, "_novalid"}, {31'd0, bus_valid_o}, 32'd0);
      core_req_i = 1'b0;
      #1;
      chk({p, "_errclr"}, {31'd0, core_err_o}, 32'd0);
      return;
    end
    chk({p, "_idle_stall"}, {31'd0, core_stall_o}, 32'd1);
    chk({p, "_idle_err"},   {31'd0, core_err_o},   32'd0);
    for (int i = 0; i <= v.rdy_dly; i++) begin
      @(negedge clk_i);
      chk({p, "_req_valid"}, {31'd0, bus_valid_o}, 32'd1);
      chk({p, "_req_stall"}, {31'd0, core_stall_o}, 32'd1);
      chk({p, "_baddr"},     bus_addr_o, v.exp_baddr);
      chk({p, "_strb"},      {28'd0, bus_strb_o}, {28'd0, v.exp_strb});
      chk({p, "_we"},        {31'd0, bus_we_o}, {31'd0, v.wen});
      if (v.wen) chk({p, "_bwdata"}, bus_wdata_o, v.exp_bwdata);
      bus_ready_i = (i == v.rdy_dly);
      if (!v.wen) begin
        bus_rvalid_i = 1'b1;           // stray beat, must be ignored in REQ
        bus_rdata_i  = 32'hCAFE_F00D;
      end
    end
    if (!v.wen) begin
      for (int i = 0; i <= v.rv_dly; i++) begin
        @(negedge clk_i);
        bus_ready_i = 1'b0;
        chk({p, "_wait_valid"}, {31'd0, bus_valid_o}, 32'd0);
        chk({p, "_wait_stall"}, {31'd0, core_stall_o}, 32'd1);
        bus_rvalid_i = (i == v.rv_dly);
        bus_rdata_i  = (i == v.rv_dly) ? v.bus_rdata : 32'hCAFE_F00D;
      end
      last_rdata = v.exp_rdata;
    end
    @(negedge clk_i);
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b0;
    chk({p, "_done_stall"}, {31'd0, core_stall_o}, 32'd0);
    chk({p, "_done_valid"}, {31'd0, bus_valid_o}, 32'd0);
    chk({p, "_done_err"},   {31'd0, core_err_o}, 32'd0);
    chk({p, "_done_rdata"}, core_rdata_o, last_rdata);
    @(negedge clk_i);
    core_req_i = 1'b0;
    #1;
    chk({p, "_idle_after"}, {31'd0, core_stall_o}, 32'd0);
    chk({p, "_rdata_hold"}, core_rdata_o, last_rdata);
  endtask

  initial begin
    //           wen   addr          wdata         mask     rdy rv  bus_rdata     err   baddr         strb     bwdata        rdata
    vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, MASK_W,  0, 0, 32'h0,         1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0203, 32'h0000_00A5, MASK_B,  1, 0, 32'h0,         1'b0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[2]  = '{1'b1, 32'h0000_0102, 32'h0000_BEEF, MASK_H,  0, 0, 32'h0,         1'b0, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0301, 32'h0,         MASK_B,  0, 1, 32'h1234_80FF, 1'b0, 32'h0000_0300, 4'b0000, 32'h0,         32'hFFFF_FF80};
    vecs[4]  = '{1'b0, 32'h0000_0301, 32'h0,         MASK_BU, 0, 1, 32'h1234_80FF, 1'b0, 32'h0000_0300, 4'b0000, 32'h0,         32'h0000_0080};
    vecs[5]  = '{1'b0, 32'h0000_0302, 32'h0,         MASK_HU, 0, 1, 32'h1234_80FF, 1'b0, 32'h0000_0300, 4'b0000, 32'h0,         32'h0000_1234};
    vecs[6]  = '{1'b0, 32'h0000_0302, 32'h0,         MASK_H,  1, 0, 32'h8001_0000, 1'b0, 32'h0000_0300, 4'b0000, 32'h0,         32'hFFFF_8001};
    vecs[7]  = '{1'b0, 32'h0000_0104, 32'h0,         MASK_W,  3, 3, 32'h89AB_CDEF, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,         32'h89AB_CDEF};
    vecs[8]  = '{1'b0, 32'h0000_0102, 32'h0,         MASK_W,  0, 0, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0100, 32'h0,         3'b011,  0, 0, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 32'h0000_0101, 32'h0000_1234, MASK_H,  0, 0, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 32'h0000_0100, 32'h0,         3'b111,  0, 0, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         MASK_B,  0, 0, 32'h0000_007F, 1'b0, 32'h0000_0000, 4'b0000, 32'h0,         32'h0000_007F};

    reset_i      = 1'b1;
    core_req_i   = 1'b0;
    core_wen_i   = 1'b0;
    core_addr_i  = 32'h0;
    core_wdata_i = 32'h0;
    core_mask_i  = 3'b000;
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
    last_rdata   = 32'h0;
    #1;
    chk("rst_valid", {31'd0, bus_valid_o},  32'd0);
    chk("rst_stall", {31'd0, core_stall_o}, 32'd0);
    chk("rst_err",   {31'd0, core_err_o},   32'd0);
    chk("rst_rdata", core_rdata_o,          32'h0);
    chk("rst_strb",  {28'd0, bus_strb_o},   32'd0);
    chk("rst_addr",  bus_addr_o,            32'h0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    for (int k = 0; k < 13; k++) run_vec(vecs[k], k);

    // Timeout: ready never comes, abort after four REQ cycles.
    @(negedge clk_i);
    core_req_i = 1'b1; core_wen_i = 1'b0; core_addr_i = 32'h400; core_mask_i = MASK_W;
    #1;
    chk("tmo_idle_stall", {31'd0, core_stall_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("tmo_req_valid", {31'd0, bus_valid_o}, 32'd1);
      chk("tmo_req_err",   {31'd0, core_err_o},  32'd0);
    end
    @(negedge clk_i);
    chk("tmo_valid_drop", {31'd0, bus_valid_o},  32'd0);
    chk("tmo_err_pulse",  {31'd0, core_err_o},   32'd1);
    chk("tmo_stall",      {31'd0, core_stall_o}, 32'd0);
    chk("tmo_rdata",      core_rdata_o,          32'h0);
    @(negedge clk_i);
    core_req_i = 1'b0;
    #1;
    chk("tmo_err_clr",   {31'd0, core_err_o},  32'd0);
    chk("tmo_idle_valid", {31'd0, bus_valid_o}, 32'd0);
    chk("tmo_rdata_hold", core_rdata_o,         32'h0);

    // Reset while waiting for read data.
    @(negedge clk_i);
    bus_rdata_i = 32'h0000_0000;
    core_req_i = 1'b1; core_wen_i = 1'b0; core_addr_i = 32'h500; core_mask_i = MASK_W;
    @(negedge clk_i);
    bus_ready_i = 1'b1;
    @(negedge clk_i);
    bus_ready_i = 1'b0;
    chk("rstw_stall_before", {31'd0, core_stall_o}, 32'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("rstw_stall", {31'd0, core_stall_o}, 32'd0);
    chk("rstw_valid", {31'd0, bus_valid_o},  32'd0);
    @(negedge clk_i);
    reset_i      = 1'b0;
    core_req_i   = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hBAAD_F00D;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    chk("late_rvalid_rdata", core_rdata_o, 32'h0);
    chk("late_rvalid_stall", {31'd0, core_stall_o}, 32'd0);

    // Reset while presenting a request: valid must drop at once.
    core_req_i = 1'b1; core_wen_i = 1'b1; core_addr_i = 32'h700; core_mask_i = MASK_W;
    @(negedge clk_i);
    chk("rstr_valid_before", {31'd0, bus_valid_o}, 32'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("rstr_valid", {31'd0, bus_valid_o}, 32'd0);
    @(negedge clk_i);
    reset_i    = 1'b0;
    core_req_i = 1'b0;
    last_rdata = 32'h0;

    begin
      vec_t v;
      v = '{1'b0, 32'h0000_0600, 32'h0, MASK_W, 0, 0, 32'h1122_3344, 1'b0, 32'h0000_0600, 4'b0000, 32'h0, 32'h1122_3344};
      run_vec(v, 99);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
